// File: rtl/mul_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_unit_pkg
//  Purpose  : Shared types and constants for the iterative multiply unit.
//             Holds the control FSM state encoding, the iteration count and
//             a helper that produces operand magnitudes for signed operations.
//  Revision : 1.0  initial release
// ============================================================================
package mul_unit_pkg;

    // Number of radix-2 shift-add steps for a 32x32 multiply.
    localparam int MUL_ITER   = 32;
    localparam int MUL_CNT_W  = 5;
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // Two's-complement magnitude when take_abs is set and v is negative.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mul_magnitude(input logic [31:0] v,
                                                  input logic        take_abs);
        return (take_abs && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage : mul_unit_pkg
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_unit
//  Purpose  : Iterative 32x32 multiplier / multiply-accumulate for the core.
//             Supports MUL, MLA (32-bit result) and UMULL/UMLAL/SMULL/SMLAL
//             (64-bit result). One radix-2 shift-add step per enabled cycle;
//             a single fix-up cycle applies the sign and the accumulator.
//  Revision : 1.0  initial release
//
//  Ports
//    clk           core clock, rising edge
//    rst_n         asynchronous active-low reset
//    en            pipeline enable; 0 freezes every register
//    i_start       start request, accepted only in IDLE
//    i_long        1: 64-bit result, 0: 32-bit result
//    i_signed      signed operands (long forms only)
//    i_accumulate  add accumulator to the product
//    i_set_flags   S bit: update cpsr flags on completion
//    i_rm, i_rs    multiplicand, multiplier
//    i_acc_lo/hi   accumulator (hi used only for long forms)
//    i_nzcv        current cpsr flags; C and V pass through
//    o_busy        operation in progress (CALC, FIX, DONE)
//    o_done        one-cycle completion pulse
//    o_result_lo/hi  result; hi is zero for 32-bit forms
//    o_nzcv_flag   cpsr flag write strobe (DONE cycle with S=1 only)
//    o_nzcv_alu    flag values for cpsr
//
//  Timing: start sampled on edge E; CALC runs on edges E+1..E+32, FIX on
//  E+33, which raises o_done. Counting the start-sampling edge as the first,
//  o_done appears after the 34th enabled edge.
// ============================================================================
module mul_unit
    import mul_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_start,
    input  logic        i_long,
    input  logic        i_signed,
    input  logic        i_accumulate,
    input  logic        i_set_flags,
    input  logic [31:0] i_rm,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_acc_lo,
    input  logic [31:0] i_acc_hi,
    input  logic [3:0]  i_nzcv,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result_lo,
    output logic [31:0] o_result_hi,
    output logic        o_nzcv_flag,
    output logic [3:0]  o_nzcv_alu
);

    // ------------------------------------------------------------------
    // State and latched operation context
    // ------------------------------------------------------------------
    mul_state_t             r_state;
    logic [MUL_CNT_W-1:0]   r_count;
    logic [31:0]            r_mcand;      // multiplicand magnitude
    logic [31:0]            r_mplier;     // multiplier magnitude
    logic [63:0]            r_prod;       // unsigned partial product
    logic                   r_neg;        // product must be negated in FIX
    logic                   r_long;
    logic                   r_accumulate;
    logic                   r_set_flags;
    logic [31:0]            r_acc_lo;
    logic [31:0]            r_acc_hi;
    logic [1:0]             r_cv;         // latched C,V

    // Registered outputs
    logic                   r_busy;
    logic                   r_done;
    logic [31:0]            r_result_lo;
    logic [31:0]            r_result_hi;
    logic                   r_nzcv_flag;
    logic [3:0]             r_nzcv_alu;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic        w_signed_op;
    logic [63:0] w_addend;
    logic [63:0] w_prod_fixed;
    logic [63:0] w_acc_val;
    logic [63:0] w_sum;
    logic [63:0] w_result;
    logic        w_flag_n;
    logic        w_flag_z;
    logic        w_unused_nz;

    // Signedness only matters for the long forms: the low 32 bits of a
    // product are identical for signed and unsigned interpretation.
    assign w_signed_op = i_long & i_signed;

    // Multiplicand weighted by the current step index.
    assign w_addend = {32'd0, r_mcand} << r_count;

    assign w_prod_fixed = r_neg ? (~r_prod + 64'd1) : r_prod;

    assign w_acc_val = !r_accumulate ? 64'd0 :
                       r_long        ? {r_acc_hi, r_acc_lo} :
                                       {32'd0, r_acc_lo};

    // Short forms wrap modulo 2^32; upper half is forced to zero.
    assign w_sum    = w_prod_fixed + w_acc_val;
    assign w_result = r_long ? w_sum : {32'd0, w_sum[31:0]};

    assign w_flag_n = r_long ? w_result[63] : w_result[31];
    assign w_flag_z = r_long ? (w_result == 64'd0) : (w_result[31:0] == 32'd0);

    // N and Z are recomputed here; only C and V are taken from cpsr.
    assign w_unused_nz = ^i_nzcv[3:2];

    // ------------------------------------------------------------------
    // Control FSM and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_prod       <= '0;
            r_neg        <= 1'b0;
            r_long       <= 1'b0;
            r_accumulate <= 1'b0;
            r_set_flags  <= 1'b0;
            r_acc_lo     <= '0;
            r_acc_hi     <= '0;
            r_cv         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result_lo  <= '0;
            r_result_hi  <= '0;
            r_nzcv_flag  <= 1'b0;
            r_nzcv_alu   <= '0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mcand      <= mul_magnitude(i_rm, w_signed_op);
                        r_mplier     <= mul_magnitude(i_rs, w_signed_op);
                        r_neg        <= w_signed_op & (i_rm[31] ^ i_rs[31]);
                        r_long       <= i_long;
                        r_accumulate <= i_accumulate;
                        r_set_flags  <= i_set_flags;
                        r_acc_lo     <= i_acc_lo;
                        r_acc_hi     <= i_acc_hi;
                        r_cv         <= i_nzcv[1:0];
                        r_prod       <= '0;
                        r_count      <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    if (r_mplier[r_count]) begin
                        r_prod <= r_prod + w_addend;
                    end
                    // Counter wraps back to zero after the last step.
                    r_count <= r_count + MUL_CNT_W'(1);
                    if (r_count == MUL_LAST) begin
                        r_state <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    r_result_lo <= w_result[31:0];
                    r_result_hi <= w_result[63:32];
                    r_nzcv_alu  <= {w_flag_n, w_flag_z, r_cv};
                    r_nzcv_flag <= r_set_flags;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    r_done      <= 1'b0;
                    r_nzcv_flag <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all driven straight from registers
    // ------------------------------------------------------------------
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result_lo = r_result_lo;
    assign o_result_hi = r_result_hi;
    assign o_nzcv_flag = r_nzcv_flag;
    assign o_nzcv_alu  = r_nzcv_alu;

endmodule : mul_unit
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_unit
//  Purpose  : Self-checking bench for mul_unit. Directed cases plus random
//             operations compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        i_start = 1'b0;
    logic        i_long = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_accumulate = 1'b0;
    logic        i_set_flags = 1'b0;
    logic [31:0] i_rm = '0;
    logic [31:0] i_rs = '0;
    logic [31:0] i_acc_lo = '0;
    logic [31:0] i_acc_hi = '0;
    logic [3:0]  i_nzcv = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result_lo;
    logic [31:0] o_result_hi;
    logic        o_nzcv_flag;
    logic [3:0]  o_nzcv_alu;

    int n_total = 0;
    int n_bad   = 0;

    // Last completed result, used to verify outputs hold between operations.
    logic [63:0] last_res = '0;
    logic [3:0]  last_alu = '0;

    always #5 clk = ~clk;

    mul_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .i_start      (i_start),
        .i_long       (i_long),
        .i_signed     (i_signed),
        .i_accumulate (i_accumulate),
        .i_set_flags  (i_set_flags),
        .i_rm         (i_rm),
        .i_rs         (i_rs),
        .i_acc_lo     (i_acc_lo),
        .i_acc_hi     (i_acc_hi),
        .i_nzcv       (i_nzcv),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result_lo  (o_result_lo),
        .o_result_hi  (o_result_hi),
        .o_nzcv_flag  (o_nzcv_flag),
        .o_nzcv_alu   (o_nzcv_alu)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic void ref_model(input bit lng, input bit sgn, input bit acc,
                                      input bit [31:0] rm, input bit [31:0] rs,
                                      input bit [31:0] alo, input bit [31:0] ahi,
                                      input bit [3:0] nz,
                                      output bit [63:0] res, output bit [3:0] alu);
        longint  a, b;
        bit [63:0] u;
        bit [31:0] s;
        if (lng) begin
            if (sgn) begin
                a = longint'($signed(rm));
                b = longint'($signed(rs));
                u = 64'(a * b);
            end else begin
                u = {32'd0, rm} * {32'd0, rs};
            end
            if (acc) u = u + {ahi, alo};
            res = u;
            alu = {u[63], (u == 64'd0), nz[1:0]};
        end else begin
            s = rm * rs;
            if (acc) s = s + alo;
            res = {32'd0, s};
            alu = {s[31], (s == 32'd0), nz[1:0]};
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Runs one operation. stall_at/stall_len insert en=0 cycles during CALC;
    // poke_start pulses i_start while busy and watches for a spurious o_done.
    task automatic do_op(input string tag,
                         input bit lng, input bit sgn, input bit acc, input bit sf,
                         input bit [31:0] rm, input bit [31:0] rs,
                         input bit [31:0] alo, input bit [31:0] ahi,
                         input bit [3:0] nz,
                         input int stall_at, input int stall_len, input bit poke_start);
        bit [63:0] exp_res;
        bit [3:0]  exp_alu;
        int        cyc;
        bit        flag_early;
        bit        hold_err;
        int        extra_done;
        ref_model(lng, sgn, acc, rm, rs, alo, ahi, nz, exp_res, exp_alu);

        @(negedge clk);
        i_long = lng; i_signed = sgn; i_accumulate = acc; i_set_flags = sf;
        i_rm = rm; i_rs = rs; i_acc_lo = alo; i_acc_hi = ahi; i_nzcv = nz;
        i_start = 1'b1; en = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        flag_early = 1'b0;
        hold_err = 1'b0;
        check({tag, " busy_after_start"}, 64'(o_busy), 64'd1);
        while (!o_done && cyc < 200) begin
            if (o_nzcv_flag) flag_early = 1'b1;
            if ({o_result_hi, o_result_lo} !== last_res || o_nzcv_alu !== last_alu)
                hold_err = 1'b1;
            en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            i_start = poke_start && (cyc == 10 || cyc == 33);
            i_rm = 32'($urandom);
            @(negedge clk);
            cyc++;
        end
        en = 1'b1;
        i_start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(34 + stall_len));
        check({tag, " result"}, {o_result_hi, o_result_lo}, exp_res);
        check({tag, " nzcv_alu"}, 64'(o_nzcv_alu), 64'(exp_alu));
        check({tag, " nzcv_flag_done"}, 64'(o_nzcv_flag), 64'(sf));
        check({tag, " flag_before_done"}, 64'(flag_early), 64'd0);
        check({tag, " hold_prev"}, 64'(hold_err), 64'd0);
        check({tag, " busy_in_done"}, 64'(o_busy), 64'd1);
        last_res = exp_res;
        last_alu = exp_alu;

        @(negedge clk);
        check({tag, " done_pulse"}, 64'(o_done), 64'd0);
        check({tag, " flag_after"}, 64'(o_nzcv_flag), 64'd0);
        check({tag, " idle_busy"}, 64'(o_busy), 64'd0);
        check({tag, " hold_after"}, {o_result_hi, o_result_lo}, exp_res);

        if (poke_start) begin
            extra_done = 0;
            for (int k = 0; k < 40; k++) begin
                if (o_done || o_busy) extra_done++;
                @(negedge clk);
            end
            check({tag, " no_second_done"}, 64'(extra_done), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(o_busy), 64'd0);
        check({tag, " done"}, 64'(o_done), 64'd0);
        check({tag, " result"}, {o_result_hi, o_result_lo}, 64'd0);
        check({tag, " flag"}, 64'(o_nzcv_flag), 64'd0);
        check({tag, " alu"}, 64'(o_nzcv_alu), 64'd0);
    endtask

    initial begin
        bit lng, sgn, acc, sf;
        int st_len;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op("mul7x6", 0, 0, 0, 1, 32'd7, 32'd6, 32'd0, 32'd0, 4'b0011, 0, 0, 0);
        do_op("mla", 0, 0, 1, 0, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'hDEAD_BEEF, 4'b1100, 0, 0, 0);
        do_op("smull", 1, 1, 0, 1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 4'b0000, 0, 0, 0);
        do_op("umull", 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'b0101, 0, 0, 0);
        do_op("umlal_z", 1, 0, 1, 1, 32'd0, 32'd5, 32'd0, 32'd0, 4'b0010, 0, 0, 0);
        do_op("smlal_min", 1, 1, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 4'b0001, 0, 0, 0);
        do_op("stall_poke", 0, 0, 0, 1, 32'd123, 32'd456, 32'd0, 32'd0, 4'b0000, 5, 5, 1);

        // Reset in the middle of CALC (step 10)
        @(negedge clk);
        i_long = 0; i_signed = 0; i_accumulate = 0; i_set_flags = 1;
        i_rm = 32'h1234; i_rs = 32'h5678; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        last_alu = '0;
        do_op("mul3x3", 0, 0, 0, 0, 32'd3, 32'd3, 32'd0, 32'd0, 4'b0000, 0, 0, 0);

        // Random operations
        for (int n = 0; n < 30; n++) begin
            lng = 1'($urandom);
            sgn = 1'($urandom);
            acc = 1'($urandom);
            sf  = 1'($urandom);
            st_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op($sformatf("rnd%0d", n), lng, sgn, acc, sf,
                  pick_operand(), pick_operand(), pick_operand(), pick_operand(),
                  4'($urandom), int'($urandom_range(2, 30)), st_len, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mul_unit
`default_nettype wire

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have: clk  in  1  core clock, rising-edge active.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: en  in  1  pipeline enable; 0 freezes all state.
REQ-004 SHALL have: i_start  in  1  start request, sampled in IDLE with en=1.
REQ-005 SHALL have: i_long  in  1  1 = 64-bit result (xMULL/xMLAL), 0 = 32-bit (MUL/MLA).
REQ-006 SHALL have: i_signed  in  1  signed operands (SMULL/SMLAL); ignored when i_long=0.
REQ-007 SHALL have: i_accumulate  in  1  add accumulator (MLA/xMLAL).
REQ-008 SHALL have: i_set_flags  in  1  S bit.
REQ-009 SHALL have: i_rm, i_rs  in  32 each  multiplicand, multiplier.
REQ-010 SHALL have: i_acc_lo, i_acc_hi  in  32 each  accumulator; i_acc_hi used only when i_long=1.
REQ-011 SHALL have: i_nzcv  in  4  current flags from cpsr o_nzcv.
REQ-012 SHALL have: o_busy  out  1  operation in progress.
REQ-013 SHALL have: o_done  out  1  one-cycle pulse; results valid.
REQ-014 SHALL have: o_result_lo, o_result_hi  out  32 each  product; o_result_hi = 0 when i_long=0.
REQ-015 SHALL have: o_nzcv_flag  out  1  drives cpsr i_nzcv_flag; high only in the o_done cycle and only if S=1.
REQ-016 SHALL have: o_nzcv_alu  out  4  drives cpsr i_nzcv_alu.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; every transition and register update qualified by en=1.
REQ-018 In IDLE with i_start=1, SHALL latch all operand/control inputs and i_nzcv, clear the 64-bit accumulator, load iteration counter 0, and enter CALC.
REQ-019 Signed ops SHALL operate on magnitudes of rm and rs and record sign = rm[31] XOR rs[31]; unsigned ops SHALL treat operands as 32-bit unsigned.
REQ-020 CALC SHALL perform one radix-2 shift-add step per enabled cycle (add multiplicand shifted by counter when multiplier bit set), exactly 32 steps; counter 31 -> FIX.
REQ-021 FIX SHALL, in one cycle, negate the 64-bit product if sign=1, then add {acc_hi,acc_lo} (long) or acc_lo (short) if accumulate, modulo 2^64 / 2^32.
REQ-022 DONE SHALL assert o_done for exactly one enabled cycle, then return to IDLE.
REQ-023 Latency SHALL be 34 enabled cycles from the start-sampling edge to o_done; each en=0 cycle extends it by one.
REQ-024 o_busy SHALL be 1 in CALC, FIX, DONE; i_start while busy SHALL be ignored.
REQ-025 Flags: N = result[63] (long) or result[31] (short); Z = all 64 (long) / low 32 (short) result bits zero; C and V = latched i_nzcv[1:0].
REQ-026 o_result_* and o_nzcv_alu SHALL hold their values after DONE until the next start reaches DONE.
REQ-027 o_nzcv_flag SHALL be 0 in all states except DONE with latched S=1.

Reset
REQ-028 rst_n=0 SHALL, at any time including mid-operation, force IDLE and zero o_busy, o_done, o_result_lo, o_result_hi, o_nzcv_flag, o_nzcv_alu, counter, and internal registers.
REQ-029 After rst_n deassertion, the first accepted start SHALL occur no earlier than the next enabled edge.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, CALC, FIX, DONE) and constant MUL_ITER = 32.
REQ-031 The block SHALL be a single module; no sub-module required; output wiring to cpsr SHALL be direct (o_nzcv_flag -> i_nzcv_flag, o_nzcv_alu -> i_nzcv_alu).

Verification
REQ-032 MUL 7 x 6, S=1, i_nzcv=0011 -> o_done 34 cycles after start; lo=0x0000002A, hi=0; o_nzcv_alu=0011, o_nzcv_flag=1 for one cycle.
REQ-033 MLA 0xFFFFFFFF x 2 + 3, S=0 -> lo=0x00000001; o_nzcv_flag stays 0 throughout.
REQ-034 SMULL -2 x 3, S=1, i_nzcv=0000 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; o_nzcv_alu=1000.
REQ-035 UMULL 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; UMLAL 0 x 5 + 0 with S=1 -> o_nzcv_alu Z=1.
REQ-036 en=0 for 5 cycles during CALC -> o_done at cycle 39; i_start pulsed while busy -> no second o_done.
REQ-037 rst_n asserted at CALC step 10 -> o_busy=0 and all outputs 0 at once; new MUL 3 x 3 then completes with lo=9 in 34 cycles.
